// File: rtl/alu_mult_seq.sv
// alu_mult_seq: unsigned shift-and-add multiplier that borrows the shared
// execute-stage ALU (ADD op) through an alu_req/alu_gnt handshake.
// Produces the low 32 bits of op_a*op_b plus an unsigned overflow flag.
//
// Optional feature macro: MULT_EARLY_EXIT_EN
//   defined   -> RUN finishes as soon as the remaining multiplier is zero
//   undefined -> always exactly N_BITS granted RUN cycles (fixed latency)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one ALU add per granted cycle, stalls while alu_gnt=0
// DONE  | done pulse; start here chains straight back into RUN
module alu_mult_seq #(
    parameter int N_BITS = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        alu_req,
    input  logic        alu_gnt,
    output logic [3:0]  alu_aluop,
    output logic [31:0] alu_port_a,
    output logic [31:0] alu_port_b,
    input  logic [31:0] alu_output
);

    localparam logic [3:0]  ALU_ADD     = 4'b0010;
    localparam logic [32:0] MASK_EXT    = (33'd1 << N_BITS) - 33'd1;
    localparam logic [31:0] MPLIER_MASK = MASK_EXT[31:0];
    localparam logic [5:0]  LAST_CNT    = 6'(N_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        lost_q, lost_d;
    logic        ovf_int_q, ovf_int_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        alu_req_q, alu_req_d;
    logic        early_exit;
    logic        load;

    // Next-state and datapath: load on accepted start, one add per granted RUN cycle
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        lost_d    = lost_q;
        ovf_int_d = ovf_int_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
`ifdef MULT_EARLY_EXIT_EN
        early_exit = (mplier_q == 32'd0);
`else
        early_exit = 1'b0;
`endif
        load = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (early_exit) begin
                    result_d = acc_q;
                    ovf_d    = ovf_int_q;
                    state_d  = S_DONE;
                end else if (alu_gnt) begin
                    if (mplier_q[0]) begin
                        acc_d = alu_output;
                        // a wrapped add or a partial product already past bit 31
                        if ((alu_output < acc_q) || lost_q) ovf_int_d = 1'b1;
                    end
                    lost_d   = lost_q | mcand_q[31];
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        result_d = acc_d;
                        ovf_d    = ovf_int_d;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = start ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            acc_d     = 32'd0;
            mcand_d   = op_a;
            mplier_d  = op_b & MPLIER_MASK;
            cnt_d     = 6'd0;
            lost_d    = 1'b0;
            ovf_int_d = 1'b0;
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
`ifdef MULT_EARLY_EXIT_EN
        // the early-exit cycle does not consume the ALU
        alu_req_d = (state_d == S_RUN) && (mplier_d != 32'd0);
`else
        alu_req_d = (state_d == S_RUN);
`endif
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            acc_q     <= 32'd0;
            mcand_q   <= 32'd0;
            mplier_q  <= 32'd0;
            cnt_q     <= 6'd0;
            lost_q    <= 1'b0;
            ovf_int_q <= 1'b0;
            result_q  <= 32'd0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
            ovf_int_q <= ovf_int_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_req_q <= alu_req_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign ovf        = ovf_q;
    assign alu_req    = alu_req_q;
    assign alu_aluop  = ALU_ADD;
    assign alu_port_a = (state_q == S_RUN) ? acc_q : 32'd0;
    assign alu_port_b = (state_q == S_RUN) ? mcand_q : 32'd0;

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Multi-cycle unsigned multiply sequencer that reuses the shared datapath ALU (ADD op) instead of adding a dedicated multiplier.
- Sits beside the execute stage and borrows the ALU through a req/gnt handshake with the execute-stage ALU mux.
- Computes the low word of op_a*op_b by shift-and-add, one ALU add per granted cycle.
- Flags unsigned overflow when the product exceeds 32 bits.

Parameters:
- N_BITS, 32, number of multiplier bits processed (1..32); op_b bits above N_BITS-1 are ignored.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  reset, synchronous, active-low.
- start  input  1  request a multiply; sampled in IDLE and DONE only.
- op_a  input  32 (word_t)  multiplicand.
- op_b  input  32 (word_t)  multiplier.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result/ovf valid.
- result  output  32 (word_t)  product low word; held until next accepted start.
- ovf  output  1  product did not fit in 32 bits; held with result.
- alu_req  output  1  requests ALU ownership.
- alu_gnt  input  1  ALU granted to this block this cycle.
- alu_aluop  output  aluop_t  ALU opcode driven to the shared ALU.
- alu_port_a  output  32 (word_t)  ALU Port_A.
- alu_port_b  output  32 (word_t)  ALU Port_B.
- alu_output  input  32 (word_t)  ALU Output_Port, combinational in the same cycle.

Behaviour:
- Interface is fixed: one clock (CLK); reset nRST is synchronous and active-low.
- Reset, sampled on CLK while nRST=0:
  - state=IDLE; busy, done, ovf and alu_req are 0; result=0.
  - Internal acc, mcand, mplier, cnt and lost are 0.
  - Reset in RUN aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads acc=0, mcand=op_a, mplier=op_b, cnt=0, lost=0, then goes to RUN.
  - Otherwise stays in IDLE.
- RUN:
  - busy=1 and alu_req=1.
  - alu_aluop=ALU_ADD, alu_port_a=acc, alu_port_b=mcand.
  - alu_gnt=0: all internal state holds (stall); no timeout.
  - alu_gnt=1, on each granted cycle:
    - If mplier[0]=1: acc<=alu_output. Set ovf_int if alu_output < acc (unsigned wrap) or lost=1.
    - lost <= lost | mcand[31]; mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
    - If cnt==N_BITS-1: result<=new acc value, ovf<=final ovf_int, next state DONE.
  - start is ignored in RUN.
- DONE:
  - done=1 for exactly this cycle; busy=0, alu_req=0.
  - start=1 reloads operands and goes straight to RUN (back-to-back ops).
  - Otherwise goes to IDLE.
- Outside RUN: alu_req=0, alu_port_a=0, alu_port_b=0, alu_aluop=ALU_ADD. The ALU mux ignores these when not granted.
- Latency with alu_gnt held 1:
  - start at edge k, RUN during cycles k+1..k+N_BITS, done at cycle k+N_BITS+1.
  - Each deasserted-gnt cycle in RUN adds one cycle.
- ovf is not cleared until the next accepted start; result=0 and ovf=0 before the first operation.
- Operands are sampled only at accept; later op_a/op_b changes have no effect.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined:
  - In RUN, if mplier==0 at the start of a cycle, the next state is DONE regardless of alu_gnt.
  - result<=acc, ovf<=ovf_int, no ALU op is consumed that cycle, and alu_req is 0 that cycle.
  - Result and ovf values are identical to the non-early path.
- Undefined: always exactly N_BITS granted RUN cycles, fixed latency.

Test Plan:
- Reset, gnt=1, start with op_a=3, op_b=5 at cycle 0 -> busy cycles 1..32, done=1 at cycle 33 only, result=15, ovf=0 (no macro).
- op_a=0xFFFF_FFFF, op_b=2 -> result=0xFFFF_FFFE, ovf=1; op_a=0x8000_0000, op_b=1 -> result=0x8000_0000, ovf=0.
- op_a=7, op_b=9 with alu_gnt alternating 1/0 starting 1 -> alu_req high throughout RUN, done at cycle 65, result=63; start pulsed mid-RUN with other operands is ignored.
- nRST=0 for one cycle at cycle 10 of an op -> next cycle IDLE, busy=0, result=0, no done; new start 6*7 -> result=42.
- Back-to-back: start held high across DONE with 2*3 then 4*5 -> done pulses with result 6 then 20, RUN re-entered directly from DONE with no IDLE cycle.
- MULT_EARLY_EXIT_EN defined, op_a=7, op_b=1, gnt=1, start at cycle 0 -> done at cycle 3, result=7, ovf=0. Undefined -> done at cycle 33.
